// File: rtl/adc_arbiter.sv
// Round-robin arbiter sharing one ADC capture block between two requesters,
// with a post-conversion idle gap and a watchdog on a missing conversion-complete.
module adc_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              req_a,
  input  logic              req_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] data_out,
  output logic              ack_err,
  output logic              err_sticky,
  input  logic              err_clr,
  output logic              busy,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // Owner encoding: 0 = requester A, 1 = requester B.
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  logic [1:0]        state, state_nx;
  logic              owner, owner_nx;
  logic              last_owner, last_owner_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nx;
  logic              start_nx;
  logic              ack_a_nx, ack_b_nx, ack_err_nx;
  logic              sticky_nx;
  logic [DATA_W-1:0] data_nx;
  logic              finish;

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= OWN_A;
      last_owner <= OWN_B;
      cnt        <= '0;
      gap_cnt    <= '0;
      adc_start  <= 1'b0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      ack_err    <= 1'b0;
      err_sticky <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      cnt        <= cnt_nx;
      gap_cnt    <= gap_cnt_nx;
      adc_start  <= start_nx;
      ack_a      <= ack_a_nx;
      ack_b      <= ack_b_nx;
      ack_err    <= ack_err_nx;
      err_sticky <= sticky_nx;
      busy       <= (state_nx != S_IDLE);
      data_out   <= data_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    cnt_nx        = cnt;
    gap_cnt_nx    = gap_cnt;
    start_nx      = 1'b0;
    ack_a_nx      = 1'b0;
    ack_b_nx      = 1'b0;
    ack_err_nx    = 1'b0;
    data_nx       = data_out;
    sticky_nx     = err_sticky & ~err_clr;
    finish        = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable && (req_a || req_b)) begin
          owner_nx = (req_a && req_b) ? ~last_owner : (req_b ? OWN_B : OWN_A);
          start_nx = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: begin
        cnt_nx   = CNT_W'(TIMEOUT - 1);
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the expiry edge still counts as success.
        if (adc_done) begin
          data_nx = adc_data;
          finish  = 1'b1;
        end else if (cnt == '0) begin
          data_nx    = '0;
          ack_err_nx = 1'b1;
          sticky_nx  = 1'b1;
          finish     = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          gap_cnt_nx = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // The ack cycle is the first cycle of the gap.
    if (finish) begin
      ack_a_nx      = (owner == OWN_A);
      ack_b_nx      = (owner == OWN_B);
      last_owner_nx = owner;
      if (GAP == 0) begin
        state_nx = S_IDLE;
      end else begin
        state_nx   = S_GAP;
        gap_cnt_nx = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
      end
    end
  end

endmodule

// File: tb/tb_adc_arbiter.sv
// Directed self-checking bench for adc_arbiter: arbitration order, timing,
// timeout, enable gating, stray completions and mid-conversion reset.
module tb_adc_arbiter;

  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b1;
  logic              req_a = 1'b0;
  logic              req_b = 1'b0;
  logic              err_clr = 1'b0;
  logic              adc_done = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              ack_a, ack_b, ack_err, err_sticky, busy, adc_start;
  logic [DATA_W-1:0] data_out;

  int tests = 0;
  int fails = 0;

  adc_arbiter #(.DATA_W(8), .TIMEOUT(64), .GAP(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_a(req_a), .req_b(req_b),
    .ack_a(ack_a), .ack_b(ack_b), .data_out(data_out), .ack_err(ack_err),
    .err_sticky(err_sticky), .err_clr(err_clr), .busy(busy),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_start(input int budget, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk); n++;
      if (adc_start) seen = 1'b1;
    end
  endtask

  task automatic wait_ack(input int budget, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk); n++;
      if (ack_a || ack_b) seen = 1'b1;
    end
  endtask

  // Returns at the negedge inside the cycle where the ack is expected.
  task automatic pulse_done(input logic [DATA_W-1:0] d);
    adc_done = 1'b1; adc_data = d;
    @(negedge clk);
    adc_done = 1'b0; adc_data = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0; tick(); reset = 1'b1; tick();
  endtask

  task automatic test_reset();
    tick();
    tests++; if ({ack_a, ack_b, ack_err, adc_start} !== 4'b0) begin fails++;
      $display("FAIL reset_pulses: got %b required 0000", {ack_a, ack_b, ack_err, adc_start}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset_sticky: got %b required 0", err_sticky); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data: got %h required 00", data_out); end
    reset = 1'b1; tick();
  endtask

  task automatic test_single();
    int n; bit seen;
    req_a = 1'b1;
    wait_start(5, n, seen);
    tests++; if (!seen || n != 1) begin fails++; $display("FAIL single_start_lat: got %0d seen=%b required 1", n, seen); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b required 1", busy); end
    tick();
    tests++; if (adc_start !== 1'b0) begin fails++; $display("FAIL single_start_width: got %b required 0", adc_start); end
    repeat (16) tick();
    pulse_done(8'hA5);
    tests++; if ({ack_a, ack_b, ack_err} !== 3'b100) begin fails++;
      $display("FAIL single_ack: got a,b,err=%b required 100", {ack_a, ack_b, ack_err}); end
    tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL single_data: got %h required a5", data_out); end
    req_a = 1'b0;
    tick(); tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: got busy=%b required 0", busy); end
  endtask

  task automatic test_round_robin();
    int n, m; bit seen; logic exp_b;
    logic [DATA_W-1:0] d;
    apply_reset();
    req_a = 1'b1; req_b = 1'b1;
    wait_start(5, n, seen);
    tests++; if (!seen || n != 1) begin fails++; $display("FAIL rr_first_start: got %0d seen=%b required 1", n, seen); end
    for (int i = 0; i < 4; i++) begin
      exp_b = logic'(i % 2);
      d = 8'h10 + DATA_W'(i);
      repeat (3) tick();
      pulse_done(d);
      tests++; if ({ack_a, ack_b} !== {~exp_b, exp_b}) begin fails++;
        $display("FAIL rr_grant%0d: got a,b=%b%b required %b%b", i, ack_a, ack_b, ~exp_b, exp_b); end
      tests++; if (data_out !== d) begin fails++; $display("FAIL rr_data%0d: got %h required %h", i, data_out, d); end
      if (exp_b) req_b = 1'b0; else req_a = 1'b0;
      if (i < 3) begin
        tick();
        req_a = 1'b1; req_b = 1'b1;
        wait_start(10, m, seen);
        // Span counts the ack cycle through the next start cycle inclusive.
        tests++; if (!seen || (m + 2) != 4) begin fails++;
          $display("FAIL rr_spacing%0d: got %0d seen=%b required 4", i, m + 2, seen); end
      end else begin
        req_a = 1'b0; req_b = 1'b0;
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int n, k; bit seen;
    req_b = 1'b1;
    wait_start(5, n, seen);
    tests++; if (!seen || n != 1) begin fails++; $display("FAIL to_start: got %0d seen=%b required 1", n, seen); end
    wait_ack(100, k, seen);
    tests++; if (!seen || k != 65) begin fails++; $display("FAIL to_latency: got %0d seen=%b required 65", k, seen); end
    tests++; if ({ack_a, ack_b, ack_err} !== 3'b011) begin fails++;
      $display("FAIL to_ack: got a,b,err=%b required 011", {ack_a, ack_b, ack_err}); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL to_data: got %h required 00", data_out); end
    tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL to_sticky_set: got %b required 1", err_sticky); end
    req_b = 1'b0;
    tick();
    tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL to_sticky_hold: got %b required 1", err_sticky); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL to_sticky_clr: got %b required 0", err_sticky); end
    repeat (2) tick();
  endtask

  task automatic test_enable();
    int n, starts; bit seen;
    enable = 1'b0; req_a = 1'b1; starts = 0;
    repeat (100) begin
      tick();
      if (adc_start || busy) starts++;
    end
    tests++; if (starts != 0) begin fails++; $display("FAIL en_gate: got %0d active cycles required 0", starts); end
    enable = 1'b1;
    wait_start(5, n, seen);
    tests++; if (!seen || n != 1) begin fails++; $display("FAIL en_start: got %0d seen=%b required 1", n, seen); end
    repeat (3) tick();
    enable = 1'b0;
    repeat (3) tick();
    pulse_done(8'h5A);
    tests++; if ({ack_a, ack_b, ack_err} !== 3'b100) begin fails++;
      $display("FAIL en_midwait_ack: got a,b,err=%b required 100", {ack_a, ack_b, ack_err}); end
    tests++; if (data_out !== 8'h5A) begin fails++; $display("FAIL en_data: got %h required 5a", data_out); end
    req_a = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_stray_done();
    int n; bit seen;
    req_b = 1'b1;
    wait_start(5, n, seen);
    tests++; if (!seen) begin fails++; $display("FAIL stray_start: got none required start"); end
    repeat (2) tick();
    pulse_done(8'h77);
    tests++; if ({ack_a, ack_b} !== 2'b01 || data_out !== 8'h77) begin fails++;
      $display("FAIL stray_setup: got a,b=%b%b data=%h required 01 77", ack_a, ack_b, data_out); end
    req_b = 1'b0;
    pulse_done(8'hEE);
    tests++; if ({ack_a, ack_b} !== 2'b00 || data_out !== 8'h77) begin fails++;
      $display("FAIL stray_gap: got a,b=%b%b data=%h required 00 77", ack_a, ack_b, data_out); end
    tick();
    pulse_done(8'hDD);
    tests++; if ({ack_a, ack_b, busy} !== 3'b000 || data_out !== 8'h77) begin fails++;
      $display("FAIL stray_idle: got a,b,busy=%b data=%h required 000 77", {ack_a, ack_b, busy}, data_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n; bit seen;
    req_a = 1'b1;
    wait_start(5, n, seen);
    repeat (5) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_pre_busy: got %b required 1", busy); end
    reset = 1'b0;
    #1;
    tests++; if ({ack_a, ack_b, ack_err, adc_start, busy, err_sticky} !== 6'b0) begin fails++;
      $display("FAIL rmid_outputs: got %b required 000000", {ack_a, ack_b, ack_err, adc_start, busy, err_sticky}); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL rmid_data: got %h required 00", data_out); end
    req_a = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    req_b = 1'b1;
    wait_start(5, n, seen);
    tests++; if (!seen || n != 1) begin fails++; $display("FAIL rmid_restart: got %0d seen=%b required 1", n, seen); end
    repeat (4) tick();
    pulse_done(8'h3C);
    tests++; if ({ack_a, ack_b} !== 2'b01 || data_out !== 8'h3C) begin fails++;
      $display("FAIL rmid_ack: got a,b=%b%b data=%h required 01 3c", ack_a, ack_b, data_out); end
    req_b = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_enable();
    test_stray_done();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
